dmem_responder: RTL and testbench

- Data-memory responder for the 16-bit multicycle core. It sits on the core's load/store port and serves LW (opcode 1010) and SW (opcode 1001) requests.
- Handshake is valid/ready on both the request and response channels, with a configurable wait-state count.
- Word-addressed: the address is the 16-bit ALU result, used directly as the word index.
- Out-of-range accesses are flagged, never aliased.

---
 rtl/dmem_responder.sv | 165 ++++++++++++++++
 tb/tb_dmem_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder for the 16-bit multicycle core's LW/SW port.
// valid/ready request and response channels, fixed wait states, out-of-range flagged.
//
// state  | meaning
// S_IDLE | ready for a request; accept latches write/addr/wdata
// S_WAIT | counting down wait states; commit on the edge where count is zero
// S_RESP | response held until rsp_valid & rsp_ready
module dmem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [15:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [15:0]       txn_count
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic [15:0]         addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic [15:0]         txn_count_q, txn_count_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                commit;
    logic                in_idle;
    logic                commit_write;
    logic [15:0]         commit_addr;
    logic [DATA_W-1:0]   commit_wdata;
    logic                commit_err;
    logic [ADDR_W-1:0]   commit_idx;
    logic                mem_we;

    // With zero wait states the commit happens on the accept edge, so the live
    // request inputs are used instead of the not-yet-loaded latches.
    assign in_idle      = (state_q == S_IDLE);
    assign commit_write = in_idle ? req_write : wr_q;
    assign commit_addr  = in_idle ? req_addr  : addr_q;
    assign commit_wdata = in_idle ? req_wdata : wdata_q;
    assign commit_err   = (commit_addr >> ADDR_W) != 16'd0;
    assign commit_idx   = commit_addr[ADDR_W-1:0];
    assign mem_we       = commit && commit_write && !commit_err;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        txn_count_d = txn_count_q;
        commit      = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    wr_d        = req_write;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    req_ready_d = 1'b0;
                    if (WAIT_CYCLES == 0) begin
                        commit = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    commit = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                    txn_count_d = txn_count_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (commit) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = commit_err;
            rsp_rdata_d = (!commit_write && !commit_err) ? mem[commit_idx] : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            addr_q      <= 16'd0;
            wdata_q     <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            txn_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            txn_count_q <= txn_count_d;
        end
    end

    // Storage is deliberately outside the reset domain; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[commit_idx] <= commit_wdata;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign txn_count = txn_count_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: four instances with 0, 1, 3 and 4 wait states
// exercising loads, stores, range errors, backpressure, mid-transaction reset and count wrap.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n     [4];
    logic        req_valid [4];
    logic        req_ready [4];
    logic        req_write [4];
    logic [15:0] req_addr  [4];
    logic [15:0] req_wdata [4];
    logic        rsp_valid [4];
    logic        rsp_ready [4];
    logic [15:0] rsp_rdata [4];
    logic        rsp_err   [4];
    logic [15:0] txn_count [4];
    logic [15:0] exp_txn   [4];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : gen_dut
        dmem_responder #(
            .ADDR_W     (8),
            .DATA_W     (16),
            .WAIT_CYCLES((g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 4)
        ) u_dut (
            .clk      (clk),
            .reset    (rst_n[g]),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_write(req_write[g]),
            .req_addr (req_addr[g]),
            .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_ready(rsp_ready[g]),
            .rsp_rdata(rsp_rdata[g]),
            .rsp_err  (rsp_err[g]),
            .txn_count(txn_count[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a request, wait (bounded) for the accept edge, then scramble inputs.
    task automatic issue(input int i, input logic w, input logic [15:0] a, input logic [15:0] d);
        int n;
        n = 0;
        @(negedge clk);
        req_valid[i] = 1'b1;
        req_write[i] = w;
        req_addr[i]  = a;
        req_wdata[i] = d;
        while (!req_ready[i] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 32'(n < 20), 32'd1);
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
        req_write[i] = ~w;
        req_addr[i]  = a ^ 16'h0055;
        req_wdata[i] = ~d;
    endtask

    // Wait for the response, check it, optionally stall rsp_ready, then check the handshake.
    task automatic collect(input int i, input int hold, input int exp_lat,
                           input logic [15:0] exp_d, input logic exp_e, input string tag);
        int lat;
        lat = 0;
        rsp_ready[i] = (hold == 0);
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid[i] && lat < 20);
        check({tag, "_lat"},   32'(lat),          32'(exp_lat));
        check({tag, "_rdata"}, 32'(rsp_rdata[i]), 32'(exp_d));
        check({tag, "_err"},   32'(rsp_err[i]),   32'(exp_e));
        check({tag, "_rdy0"},  32'(req_ready[i]), 32'd0);
        check({tag, "_txn0"},  32'(txn_count[i]), 32'(exp_txn[i]));
        for (int h = 1; h <= hold; h++) begin
            req_valid[i] = h[0];
            @(negedge clk);
            check({tag, "_hold_vld"}, 32'(rsp_valid[i]), 32'd1);
            check({tag, "_hold_dat"}, 32'(rsp_rdata[i]), 32'(exp_d));
            check({tag, "_hold_rdy"}, 32'(req_ready[i]), 32'd0);
            check({tag, "_hold_txn"}, 32'(txn_count[i]), 32'(exp_txn[i]));
        end
        req_valid[i] = 1'b0;
        rsp_ready[i] = 1'b1;
        @(negedge clk);
        exp_txn[i] = exp_txn[i] + 16'd1;
        check({tag, "_vld_drop"}, 32'(rsp_valid[i]), 32'd0);
        check({tag, "_err_drop"}, 32'(rsp_err[i]),   32'd0);
        check({tag, "_txn1"},     32'(txn_count[i]), 32'(exp_txn[i]));
        check({tag, "_keep"},     32'(rsp_rdata[i]), 32'(exp_d));
        rsp_ready[i] = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 4; i++) begin
            rst_n[i]     = 1'b0;
            req_valid[i] = 1'b0;
            req_write[i] = 1'b0;
            req_addr[i]  = 16'd0;
            req_wdata[i] = 16'd0;
            rsp_ready[i] = 1'b0;
            exp_txn[i]   = 16'd0;
        end
        #23;
        for (int i = 0; i < 4; i++) begin
            check("rst_req_ready", 32'(req_ready[i]), 32'd0);
            check("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
            check("rst_rdata",     32'(rsp_rdata[i]), 32'd0);
            check("rst_err",       32'(rsp_err[i]),   32'd0);
            check("rst_txn",       32'(txn_count[i]), 32'd0);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) rst_n[i] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) check("idle_ready", 32'(req_ready[i]), 32'd1);

        // One wait state: store then load back
        issue(1, 1'b1, 16'h0010, 16'h00AB);
        collect(1, 0, 2, 16'h0000, 1'b0, "w1_sw");
        issue(1, 1'b0, 16'h0010, 16'h0000);
        collect(1, 0, 2, 16'h00AB, 1'b0, "w1_lw");

        // Zero wait states, back-to-back store/load
        issue(0, 1'b1, 16'h00FF, 16'h1234);
        collect(0, 0, 1, 16'h0000, 1'b0, "w0_sw");
        issue(0, 1'b0, 16'h00FF, 16'h0000);
        collect(0, 0, 1, 16'h1234, 1'b0, "w0_lw");

        // Out of range must flag and must not alias onto location 0
        issue(0, 1'b1, 16'h0000, 16'h5555);
        collect(0, 0, 1, 16'h0000, 1'b0, "pre_sw");
        issue(0, 1'b1, 16'h0100, 16'hBEEF);
        collect(0, 0, 1, 16'h0000, 1'b1, "oor_sw");
        issue(0, 1'b0, 16'h0000, 16'h0000);
        collect(0, 0, 1, 16'h5555, 1'b0, "oor_chk0");
        issue(0, 1'b0, 16'h00FF, 16'h0000);
        collect(0, 0, 1, 16'h1234, 1'b0, "oor_chkff");
        issue(0, 1'b0, 16'h8005, 16'h0000);
        collect(0, 0, 1, 16'h0000, 1'b1, "oor_lw");

        // Three wait states with backpressure
        issue(2, 1'b1, 16'h0005, 16'h0037);
        collect(2, 0, 4, 16'h0000, 1'b0, "w3_sw");
        issue(2, 1'b0, 16'h0005, 16'h0000);
        collect(2, 5, 4, 16'h0037, 1'b0, "bp_lw");

        // Reset while in RESP: store already committed, response dropped
        issue(2, 1'b1, 16'h0030, 16'h4242);
        rsp_ready[2] = 1'b0;
        n = 0;
        while (!rsp_valid[2] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rresp_seen", 32'(rsp_valid[2]), 32'd1);
        #2 rst_n[2] = 1'b0;
        #1;
        exp_txn[2] = 16'd0;
        check("rresp_vld", 32'(rsp_valid[2]), 32'd0);
        check("rresp_txn", 32'(txn_count[2]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n[2] = 1'b1;
        issue(2, 1'b0, 16'h0030, 16'h0000);
        collect(2, 0, 4, 16'h4242, 1'b0, "rresp_lw");

        // Four wait states: reset two cycles after accept discards the store
        issue(3, 1'b1, 16'h0020, 16'h0001);
        collect(3, 0, 5, 16'h0000, 1'b0, "w4_sw");
        issue(3, 1'b0, 16'h0020, 16'h0000);
        collect(3, 0, 5, 16'h0001, 1'b0, "w4_lw");
        issue(3, 1'b1, 16'h0020, 16'h7777);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n[3] = 1'b0;
        #1;
        exp_txn[3] = 16'd0;
        check("rwait_vld",   32'(rsp_valid[3]), 32'd0);
        check("rwait_rdy",   32'(req_ready[3]), 32'd0);
        check("rwait_rdata", 32'(rsp_rdata[3]), 32'd0);
        check("rwait_txn",   32'(txn_count[3]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n[3] = 1'b1;
        issue(3, 1'b0, 16'h0020, 16'h0000);
        collect(3, 0, 5, 16'h0001, 1'b0, "rwait_lw");
        check("rwait_txn_final", 32'(txn_count[3]), 32'd1);

        // Count wrap: preset near the top instead of running 65535 transactions
        @(negedge clk);
        force gen_dut[1].u_dut.txn_count_q = 16'hFFFE;
        #1;
        release gen_dut[1].u_dut.txn_count_q;
        exp_txn[1] = 16'hFFFE;
        #1;
        check("wrap_preset", 32'(txn_count[1]), 32'h0000FFFE);
        issue(1, 1'b0, 16'h0010, 16'h0000);
        collect(1, 0, 2, 16'h00AB, 1'b0, "wrap_a");
        issue(1, 1'b0, 16'h0010, 16'h0000);
        collect(1, 0, 2, 16'h00AB, 1'b0, "wrap_b");
        check("wrap_zero", 32'(txn_count[1]), 32'h00000000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
